// File: rtl/attopu_sequencer.sv
// Multi-cycle control sequencer for the attopu core: instruction fetch, decode settle,
// data-memory access and write-back, with PC/flag ownership and ack watchdogs.
module attopu_sequencer #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [15:0]     instr,
    input  logic            dec_halt,
    input  logic [1:0]      dec_nextPCSel,
    input  logic [15:0]     dec_addr,
    input  logic            dec_regFileWE,
    input  logic            dec_memWE,
    input  logic            dec_dAddrSel,
    input  logic            alu_cout,
    input  logic            alu_zero,
    output logic            cFlag,
    output logic            zFlag,
    output logic            regFileWE,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            fault
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StMem,
        StWb,
        StHalt,
        StFault
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     instr_q, instr_d;
    logic            c_q, c_d;
    logic            z_q, z_d;
    logic [7:0]      wdog_q, wdog_d;

    logic            timeout;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] pc_inc;

    assign timeout = (wdog_q == 8'(TIMEOUT));
    assign br_off  = PC_W'($signed(dec_addr));
    assign pc_inc  = pc_q + PC_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack in the timeout cycle still completes the access
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StFetch;
            StFetch: begin
                if (imem_ack) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                if (dec_halt) begin
                    state_d = StHalt;
                end else if (dec_dAddrSel) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ack) begin
                    state_d = StWb;
                end else if (timeout) begin
                    state_d = StFault;
                end
            end
            StWb:     state_d = StFetch;
            StHalt:   if (start) state_d = StFetch;
            StFault:  state_d = StFault;
            default:  state_d = StIdle;
        endcase
    end

    // Output decode from state
    always_comb begin
        imem_req  = (state_q == StFetch);
        dmem_req  = (state_q == StMem);
        dmem_we   = (state_q == StMem) && dec_memWE;
        regFileWE = (state_q == StWb) && dec_regFileWE;
        halted    = (state_q == StIdle) || (state_q == StHalt);
        fault     = (state_q == StFault);
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign cFlag     = c_q;
    assign zFlag     = z_q;

    // Datapath next-state: PC, instruction register, flags, watchdog
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        c_d     = c_q;
        z_d     = z_q;

        if ((state_q == StFetch) && imem_ack) begin
            instr_d = imem_rdata;
        end
        if ((state_q == StDecode) && dec_halt) begin
            pc_d = pc_inc;
        end
        if (state_q == StWb) begin
            pc_d = (dec_nextPCSel == 2'b01) ? (pc_q + br_off) : pc_inc;
            if (instr_q[15:13] == 3'b000) begin
                c_d = alu_cout;
                z_d = alu_zero;
            end
        end

        // Cleared on every state change so each wait phase starts from zero
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if ((state_q == StFetch) || (state_q == StMem)) begin
            wdog_d = wdog_q + 8'd1;
        end else begin
            wdog_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            wdog_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            c_q     <= c_d;
            z_q     <= z_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_attopu_sequencer.sv
// Directed bench for attopu_sequencer: an architectural model (pc, flags, instruction
// register, per-phase control expectations) checked every cycle, plus literal pins.
module tb_attopu_sequencer;

    localparam int unsigned PC_W = 16;
    localparam int unsigned TO   = 255;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata = '0;
    logic            imem_ack = 1'b0;
    logic [15:0]     instr;
    logic            dec_halt = 1'b0;
    logic [1:0]      dec_nextPCSel = '0;
    logic [15:0]     dec_addr = '0;
    logic            dec_regFileWE = 1'b0;
    logic            dec_memWE = 1'b0;
    logic            dec_dAddrSel = 1'b0;
    logic            alu_cout = 1'b0;
    logic            alu_zero = 1'b0;
    logic            cFlag;
    logic            zFlag;
    logic            regFileWE;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack = 1'b0;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic            fault;

    attopu_sequencer #(
        .PC_W    (PC_W),
        .RESET_PC(16'h0000),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .instr        (instr),
        .dec_halt     (dec_halt),
        .dec_nextPCSel(dec_nextPCSel),
        .dec_addr     (dec_addr),
        .dec_regFileWE(dec_regFileWE),
        .dec_memWE    (dec_memWE),
        .dec_dAddrSel (dec_dAddrSel),
        .alu_cout     (alu_cout),
        .alu_zero     (alu_zero),
        .cFlag        (cFlag),
        .zFlag        (zFlag),
        .regFileWE    (regFileWE),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .pc           (pc),
        .halted       (halted),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Architectural model state
    logic [15:0] m_pc = '0;
    logic [15:0] m_instr = '0;
    logic        m_c = 1'b0;
    logic        m_z = 1'b0;

    // Expected control outputs for the current cycle
    logic e_ireq = 1'b0, e_dreq = 1'b0, e_dwe = 1'b0, e_rfwe = 1'b0;
    logic e_halt = 1'b1, e_flt = 1'b0;
    logic chk_en = 1'b0;

    int lit_pc = -1;
    int lit_c  = -1;
    int lit_z  = -1;

    int dreq_cnt = 0;
    int dwe_cnt  = 0;
    int rfwe_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (regFileWE) rfwe_cnt++;
        if (dmem_req)  dreq_cnt++;
        if (dmem_we)   dwe_cnt++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_req",  32'(imem_req),  32'(e_ireq));
            check("imem_addr", 32'(imem_addr), 32'(m_pc));
            check("dmem_req",  32'(dmem_req),  32'(e_dreq));
            check("dmem_we",   32'(dmem_we),   32'(e_dwe));
            check("regFileWE", 32'(regFileWE), 32'(e_rfwe));
            check("halted",    32'(halted),    32'(e_halt));
            check("fault",     32'(fault),     32'(e_flt));
            check("pc",        32'(pc),        32'(m_pc));
            check("instr",     32'(instr),     32'(m_instr));
            check("cFlag",     32'(cFlag),     32'(m_c));
            check("zFlag",     32'(zFlag),     32'(m_z));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic ireq, input logic dreq, input logic dwe,
                           input logic rfwe, input logic hlt, input logic flt);
        e_ireq = ireq; e_dreq = dreq; e_dwe = dwe;
        e_rfwe = rfwe; e_halt = hlt;  e_flt = flt;
    endtask

    task automatic do_lits();
        if (lit_pc >= 0) begin
            check("lit_imem_addr", 32'(imem_addr), 32'(lit_pc));
            lit_pc = -1;
        end
        if (lit_c >= 0) begin
            check("lit_cFlag", 32'(cFlag), 32'(lit_c));
            lit_c = -1;
        end
        if (lit_z >= 0) begin
            check("lit_zFlag", 32'(zFlag), 32'(lit_z));
            lit_z = -1;
        end
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        set_exp(0, 0, 0, 0, 1, 0);
    endtask

    // One instruction: fetch (ack in cycle ilat), decode, optional memory, write-back
    task automatic do_instr(input logic [15:0] rdata, input int ilat, input logic hlt,
                            input logic [1:0] sel, input logic [15:0] off,
                            input logic rwe, input logic mwe, input logic das,
                            input int dlat, input logic co, input logic ze);
        for (int k = 1; k <= ilat; k++) begin
            step();
            if (k == 1) do_lits();
            start = 1'b0; dmem_ack = 1'b0;
            imem_rdata = rdata;
            imem_ack = (k == ilat);
            set_exp(1, 0, 0, 0, 0, 0);
        end
        step();
        imem_ack = 1'b0;
        imem_rdata = 16'hDEAD;
        m_instr = rdata;
        dec_halt = hlt; dec_nextPCSel = sel; dec_addr = off;
        dec_regFileWE = rwe; dec_memWE = mwe; dec_dAddrSel = das;
        set_exp(0, 0, 0, 0, 0, 0);
        if (hlt) begin
            @(negedge clk);
            #1;
            m_pc = m_pc + 16'd1;
            step();
            dec_halt = 1'b0;
            set_exp(0, 0, 0, 0, 1, 0);
            return;
        end
        if (das) begin
            for (int k = 1; k <= dlat; k++) begin
                step();
                dmem_ack = (k == dlat);
                set_exp(0, 1, mwe, 0, 0, 0);
            end
        end
        step();
        dmem_ack = 1'b0;
        alu_cout = co; alu_zero = ze;
        set_exp(0, 0, 0, rwe, 0, 0);
        @(negedge clk);
        #1;
        if (rdata[15:13] == 3'b000) begin
            m_c = co;
            m_z = ze;
        end
        m_pc = (sel == 2'b01) ? m_pc + off : m_pc + 16'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL bench_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int d0, w0, r0;
        #12;
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();
        set_exp(0, 0, 0, 0, 1, 0);
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_halted", 32'(halted), 32'h1);

        // Reset while a fetch is outstanding drops the request at once
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            step();
            start = 1'b0;
            set_exp(1, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        chk_en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_imem_req", 32'(imem_req), 32'h0);
        check("midreset_halted", 32'(halted), 32'h1);
        #3;
        rst_n = 1'b1;
        set_exp(0, 0, 0, 0, 1, 0);
        chk_en = 1'b1;

        // ALU op: flags captured, one write pulse
        r0 = rfwe_cnt;
        pulse_start();
        do_instr(16'h0000, 1, 0, 2'b00, 16'h0, 1, 0, 0, 0, 1, 0);
        check("alu_rfwe_pulses", 32'(rfwe_cnt - r0), 32'd1);
        lit_pc = 1; lit_c = 1; lit_z = 0;

        // Branches: 1 -> 5 -> 8 -> 5 -> 3
        do_instr(16'hC004, 2, 0, 2'b01, 16'h0004, 0, 0, 0, 0, 0, 1);
        lit_pc = 5; lit_c = 1; lit_z = 0;
        do_instr(16'hC003, 1, 0, 2'b01, 16'h0003, 0, 0, 0, 0, 0, 0);
        lit_pc = 8;
        do_instr(16'hC003, 1, 0, 2'b01, 16'hFFFD, 0, 0, 0, 0, 0, 0);
        do_instr(16'hC003, 1, 0, 2'b01, 16'hFFFE, 0, 0, 0, 0, 0, 0);
        lit_pc = 3;

        // Store with ack in the fifth MEM cycle
        d0 = dreq_cnt; w0 = dwe_cnt; r0 = rfwe_cnt;
        do_instr(16'h8000, 3, 0, 2'b00, 16'h0, 0, 1, 1, 5, 0, 0);
        check("store_dmem_req_cycles", 32'(dreq_cnt - d0), 32'd5);
        check("store_dmem_we_cycles", 32'(dwe_cnt - w0), 32'd5);
        check("store_rfwe_pulses", 32'(rfwe_cnt - r0), 32'd0);
        lit_pc = 4;

        // Load, then an ALU op and a non-ALU op that must leave flags alone
        do_instr(16'hA000, 1, 0, 2'b00, 16'h0, 1, 0, 1, 1, 1, 1);
        lit_pc = 5; lit_c = 1; lit_z = 0;
        do_instr(16'h0000, 1, 0, 2'b00, 16'h0, 1, 0, 0, 0, 0, 1);
        lit_c = 0; lit_z = 1;
        do_instr(16'h2000, 1, 0, 2'b00, 16'h0, 1, 0, 0, 0, 1, 0);
        lit_pc = 7; lit_c = 0; lit_z = 1;

        // Halt at 7, acks while idle are ignored, resume at 8
        do_instr(16'hE000, 1, 1, 2'b00, 16'h0, 0, 0, 0, 0, 0, 0);
        check("halt_pc", 32'(pc), 32'h8);
        check("halt_halted", 32'(halted), 32'h1);
        for (int k = 0; k < 4; k++) begin
            step();
            imem_ack = 1'b1; dmem_ack = 1'b1;
            set_exp(0, 0, 0, 0, 1, 0);
        end
        pulse_start();
        lit_pc = 8;
        do_instr(16'hC000, 1, 0, 2'b01, 16'hFFF7, 0, 0, 0, 0, 0, 0);
        lit_pc = 16'hFFFF;
        do_instr(16'h0001, 1, 0, 2'b00, 16'h0, 1, 0, 0, 0, 1, 1);
        lit_pc = 0; lit_c = 1; lit_z = 1;

        // Fetch never acknowledged: TO+1 request cycles, then sticky fault
        for (int k = 1; k <= int'(TO) + 1; k++) begin
            step();
            if (k == 1) do_lits();
            imem_ack = 1'b0;
            set_exp(1, 0, 0, 0, 0, 0);
        end
        step();
        set_exp(0, 0, 0, 0, 0, 1);
        check("fault_set", 32'(fault), 32'h1);
        for (int k = 0; k < 6; k++) begin
            step();
            start = (k % 2 == 0);
            set_exp(0, 0, 0, 0, 0, 1);
        end

        // Asynchronous reset out of FAULT
        @(negedge clk);
        chk_en = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_halted", 32'(halted), 32'h1);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_dmem_req", 32'(dmem_req), 32'h0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_cFlag", 32'(cFlag), 32'h0);
        check("rst_zFlag", 32'(zFlag), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
